// File: rtl/booth_arb_pkg.sv
// Shared types and default constants for the Booth multiplier arbiter.
package booth_arb_pkg;

  // Default configuration values used by the top-level parameters.
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_WIDTH       = 15;
  localparam int DEF_TIMEOUT_CYC = 64;

  // Transaction FSM. One transaction is in flight at a time.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/booth_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting at
// ptr_i and returns the first requester found as a one-hot grant and an ID.
module booth_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  winner_o,
  output logic             any_req_o
);

  // One extra bit so ptr + offset can exceed N_REQ before the wrap.
  localparam int IW = ID_W + 1;

  logic [IW-1:0] idx_ext;

  // Priority scan from ptr_i, wrapping modulo N_REQ; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant_o   = '0;
    winner_o  = '0;
    any_req_o = 1'b0;
    idx_ext   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_ext = {1'b0, ptr_i} + IW'(k);
      if (idx_ext >= IW'(N_REQ)) begin
        idx_ext = idx_ext - IW'(N_REQ);
      end
      if (!any_req_o && req_i[idx_ext[ID_W-1:0]]) begin
        any_req_o                     = 1'b1;
        grant_o[idx_ext[ID_W-1:0]]    = 1'b1;
        winner_o                      = idx_ext[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin scheduler sharing one sequential radix-8 Booth multiplier
// among N_REQ requesters. Operand pairs with a zero operand bypass the
// multiplier. Optional WAIT timeout is enabled by defining the macro
// BOOTH_ARB_TIMEOUT_EN; without it resp_err is tied low and WAIT lasts
// until the multiplier reports done.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int N_REQ       = DEF_N_REQ,
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_m,
  input  logic [N_REQ*WIDTH-1:0] req_q,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [2*WIDTH-1:0]     resp_prod,
  output logic                   resp_err,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_dataM,
  output logic [WIDTH-1:0]       mul_dataQ,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_prod
);

  // Reject configurations the picker and counters are not sized for.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("booth_mul_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("booth_mul_arbiter: TIMEOUT_CYC must be at least 2");
  end

  state_e               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      ptr_d;
  logic                 resp_valid_q;
  logic [ID_W-1:0]      resp_id_q;
  logic [2*WIDTH-1:0]   resp_prod_q;
  logic                 mul_start_q;
  logic [WIDTH-1:0]     mul_dataM_q;
  logic [WIDTH-1:0]     mul_dataQ_q;
  logic                 wait_first_q;

  logic [N_REQ-1:0]     grant;
  logic [ID_W-1:0]      winner;
  logic                 any_req;
  logic [WIDTH-1:0]     m_arr [N_REQ];
  logic [WIDTH-1:0]     q_arr [N_REQ];
  logic [WIDTH-1:0]     sel_m;
  logic [WIDTH-1:0]     sel_q;
  logic                 sel_zero;
  logic                 grant_en;

  // Unpack the flat operand buses into per-requester words.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign m_arr[gi] = req_m[gi*WIDTH +: WIDTH];
    assign q_arr[gi] = req_q[gi*WIDTH +: WIDTH];
  end

  booth_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Grants are only offered from a settled IDLE state; the reset term keeps
  // req_ready low while rst is held even though the state is already IDLE.
  assign grant_en  = (state_q == ST_IDLE) && !rst;
  assign req_ready = grant_en ? grant : '0;

  assign sel_m    = m_arr[winner];
  assign sel_q    = q_arr[winner];
  assign sel_zero = (sel_m == '0) || (sel_q == '0);

  // Pointer moves one past the winner, wrapping at N_REQ.
  assign ptr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_prod  = resp_prod_q;
  assign mul_start  = mul_start_q;
  assign mul_dataM  = mul_dataM_q;
  assign mul_dataQ  = mul_dataQ_q;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             resp_err_q;
  logic             timeout_hit;

  // Counter holds the number of WAIT cycles already spent before this one.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign resp_err    = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Transaction FSM with registered response and multiplier-side outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_prod_q  <= '0;
      mul_start_q  <= 1'b0;
      mul_dataM_q  <= '0;
      mul_dataQ_q  <= '0;
      wait_first_q <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      mul_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            ptr_q     <= ptr_d;
            resp_id_q <= winner;
`ifdef BOOTH_ARB_TIMEOUT_EN
            resp_err_q <= 1'b0;
`endif
            if (sel_zero) begin
              // Zero operand: product is known, the multiplier is untouched
              // so its data inputs keep the last started operands.
              resp_prod_q  <= '0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              mul_dataM_q <= sel_m;
              mul_dataQ_q <= sel_q;
              mul_start_q <= 1'b1;
              state_q     <= ST_START;
            end
          end
        end

        ST_START: begin
          wait_first_q <= 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
          wait_cnt_q   <= '0;
`endif
          state_q      <= ST_WAIT;
        end

        ST_WAIT: begin
          // The first WAIT cycle may still see done from an older operation.
          wait_first_q <= 1'b0;
          if (!wait_first_q && mul_done) begin
            resp_prod_q  <= mul_prod;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            resp_prod_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed self-checking bench for booth_mul_arbiter (N_REQ=4, WIDTH=15,
// TIMEOUT_CYC=16). A behavioural multiplier keeps mul_done as a level that
// stays high after completion, so the next operation starts with a stale done.
module tb_booth_mul_arbiter;

  localparam int N  = 4;
  localparam int W  = 15;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_m;
  logic [N*W-1:0]  req_q;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic [2*W-1:0]  resp_prod;
  logic            resp_err;
  logic            mul_start;
  logic [W-1:0]    mul_dataM;
  logic [W-1:0]    mul_dataQ;
  logic            mul_done = 1'b0;
  logic [2*W-1:0]  mul_prod = '0;

  int n_tests = 0;
  int n_fail  = 0;

  booth_mul_arbiter #(
    .N_REQ       (N),
    .WIDTH       (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_m      (req_m),
    .req_q      (req_q),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
    .resp_err   (resp_err),
    .mul_start  (mul_start),
    .mul_dataM  (mul_dataM),
    .mul_dataQ  (mul_dataQ),
    .mul_done   (mul_done),
    .mul_prod   (mul_prod)
  );

  always #5 clk = ~clk;

  // Multiplier model: result 8 cycles after start, done held high afterwards,
  // old done only cleared two cycles after the start pulse.
  logic              hang  = 1'b0;
  logic              mbusy = 1'b0;
  int                mcnt  = 0;
  logic signed [29:0] mstore;

  always @(negedge clk) begin
    if (mul_start) begin
      mbusy  = 1'b1;
      mcnt   = 0;
      mstore = $signed(mul_dataM) * $signed(mul_dataQ);
    end else if (mbusy) begin
      mcnt++;
      if (mcnt == 2) mul_done = 1'b0;
      if (mcnt == 8) begin
        mbusy = 1'b0;
        if (!hang) begin
          mul_done = 1'b1;
          mul_prod = mstore;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] p30(input longint v);
    logic [29:0] r;
    r = v[29:0];
    return r;
  endfunction

  function automatic logic [14:0] w15(input int v);
    logic [14:0] r;
    r = v[14:0];
    return r;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_req(input int i, input int m, input int q);
    req_m[i*W +: W] = w15(m);
    req_q[i*W +: W] = w15(q);
  endtask

  // Leaves time just after the grant became visible (combinational ready).
  task automatic wait_grant(input string tag, output int id);
    id = -1;
    for (int k = 0; k < 40 && id < 0; k++) begin
      #1;
      for (int j = 0; j < N; j++) if (req_ready[j]) id = j;
      if (id < 0) cyc();
    end
    check({tag, " grant seen"}, 64'(id >= 0), 64'd1);
  endtask

  task automatic wait_resp(input string tag);
    for (int k = 0; k < 60 && !resp_valid; k++) cyc();
    check({tag, " resp seen"}, 64'(resp_valid), 64'd1);
  endtask

  task automatic take_resp(input string tag);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    check({tag, " resp dropped"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int starts;
    int k;
    int order [5];
    longint prod [4];
    logic seen;

    rst        = 1'b1;
    req_valid  = '0;
    req_m      = '0;
    req_q      = '0;
    resp_ready = 1'b0;
    cyc(3);

    // Reset state
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_id",    64'(resp_id),    64'd0);
    check("rst resp_prod",  64'(resp_prod),  64'd0);
    check("rst resp_err",   64'(resp_err),   64'd0);
    check("rst mul_start",  64'(mul_start),  64'd0);
    check("rst mul_dataM",  64'(mul_dataM),  64'd0);
    check("rst mul_dataQ",  64'(mul_dataQ),  64'd0);
    req_valid = 4'b1111;
    #1;
    check("rst req_ready",  64'(req_ready),  64'd0);
    req_valid = '0;
    rst = 1'b0;
    cyc();

    // Single request: 3 * -5 = -15 from requester 2
    set_req(2, 3, -5);
    req_valid = 4'b0100;
    wait_grant("t1", id);
    check("t1 ready onehot", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = '0;
    check("t1 start",  64'(mul_start), 64'd1);
    check("t1 dataM",  64'(mul_dataM), 64'(15'd3));
    check("t1 dataQ",  64'(mul_dataQ), 64'(15'h7FFB));
    cyc();
    check("t1 start 1 cycle", 64'(mul_start), 64'd0);
    starts = 0;
    for (k = 0; k < 60 && !resp_valid; k++) begin
      if (mul_start) starts++;
      cyc();
    end
    check("t1 resp seen",    64'(resp_valid), 64'd1);
    check("t1 no restart",   64'(starts),     64'd0);
    check("t1 resp_id",      64'(resp_id),    64'd2);
    check("t1 resp_prod",    64'(resp_prod),  64'(p30(-15)));
    check("t1 resp_err",     64'(resp_err),   64'd0);
    check("t1 dataM stable", 64'(mul_dataM),  64'(15'd3));
    take_resp("t1");

    // All four valid from ptr=0: order 0,1,2,3,0 with each own product
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_req(0, 2, 7);
    set_req(1, -4, 6);
    set_req(2, 100, -100);
    set_req(3, -16384, -16384);
    prod  = '{14, -24, -10000, 268435456};
    order = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant("t2", id);
      check($sformatf("t2 grant %0d", t), 64'(id), 64'(order[t]));
      cyc();
      wait_resp("t2");
      check($sformatf("t2 resp_id %0d", t),   64'(resp_id),   64'(order[t]));
      check($sformatf("t2 resp_prod %0d", t), 64'(resp_prod), 64'(p30(prod[order[t]])));
      take_resp("t2");
    end
    req_valid = '0;

    // Zero bypass on M (requester 1) and on Q (requester 3)
    set_req(1, 0, 123);
    req_valid = 4'b0010;
    wait_grant("t3a", id);
    check("t3a ready", 64'(req_ready), 64'b0010);
    cyc();
    req_valid = '0;
    check("t3a resp_valid", 64'(resp_valid), 64'd1);
    check("t3a resp_prod",  64'(resp_prod),  64'd0);
    check("t3a resp_id",    64'(resp_id),    64'd1);
    check("t3a no start",   64'(mul_start),  64'd0);
    take_resp("t3a");
    set_req(3, 55, 0);
    req_valid = 4'b1000;
    wait_grant("t3b", id);
    check("t3b ready", 64'(req_ready), 64'b1000);
    cyc();
    req_valid = '0;
    check("t3b resp_valid", 64'(resp_valid), 64'd1);
    check("t3b resp_prod",  64'(resp_prod),  64'd0);
    check("t3b resp_id",    64'(resp_id),    64'd3);
    check("t3b no start",   64'(mul_start),  64'd0);
    check("t3b dataM kept", 64'(mul_dataM),  64'(15'd2));
    take_resp("t3b");

    // Back-pressure: resp_ready low for 10 cycles with requester 2 waiting
    set_req(0, -7, -9);
    set_req(2, 5, 5);
    req_valid = 4'b0101;
    wait_grant("t4", id);
    check("t4 ready", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = 4'b0100;
    wait_resp("t4");
    check("t4 resp_prod", 64'(resp_prod), 64'd63);
    for (int s = 0; s < 10; s++) begin
      cyc();
      #1;
      check("t4 hold valid", 64'(resp_valid), 64'd1);
      check("t4 hold prod",  64'(resp_prod),  64'd63);
      check("t4 hold id",    64'(resp_id),    64'd0);
      check("t4 no grant",   64'(req_ready),  64'd0);
    end
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    #1;
    check("t4 next grant", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = '0;
    wait_resp("t4b");
    check("t4b resp_id",   64'(resp_id),   64'd2);
    check("t4b resp_prod", 64'(resp_prod), 64'd25);
    take_resp("t4b");

    // Reset during WAIT; the aborted op later raises a stale done (400)
    set_req(1, 20, 20);
    req_valid = 4'b0010;
    wait_grant("t5", id);
    check("t5 ready", 64'(req_ready), 64'b0010);
    cyc();
    req_valid = '0;
    cyc();
    rst = 1'b1;
    cyc();
    check("t5 rst resp_valid", 64'(resp_valid), 64'd0);
    check("t5 rst resp_id",    64'(resp_id),    64'd0);
    check("t5 rst resp_prod",  64'(resp_prod),  64'd0);
    check("t5 rst mul_start",  64'(mul_start),  64'd0);
    check("t5 rst dataM",      64'(mul_dataM),  64'd0);
    check("t5 rst dataQ",      64'(mul_dataQ),  64'd0);
    set_req(3, 11, -3);
    req_valid = 4'b1000;
    #1;
    check("t5 rst ready", 64'(req_ready), 64'd0);
    cyc(10);
    rst = 1'b0;
    wait_grant("t5b", id);
    check("t5b ready", 64'(req_ready), 64'b1000);
    cyc();
    req_valid = '0;
    wait_resp("t5b");
    check("t5b resp_id",   64'(resp_id),   64'd3);
    check("t5b resp_prod", 64'(resp_prod), 64'(p30(-33)));
    check("t5b resp_err",  64'(resp_err),  64'd0);
    take_resp("t5b");

    // Multiplier never completes
    hang = 1'b1;
    set_req(0, 9, 9);
    req_valid = 4'b0001;
    wait_grant("t6", id);
    cyc();
    req_valid = '0;
    check("t6 start", 64'(mul_start), 64'd1);
`ifdef BOOTH_ARB_TIMEOUT_EN
    k = 0;
    while (!resp_valid && k < 100) begin
      cyc();
      k++;
    end
    check("t6 timeout latency", 64'(k),         64'd17);
    check("t6 resp_err",        64'(resp_err),  64'd1);
    check("t6 resp_prod",       64'(resp_prod), 64'd0);
    take_resp("t6");
`else
    seen = 1'b0;
    for (int s = 0; s < 40; s++) begin
      cyc();
      if (resp_valid) seen = 1'b1;
    end
    check("t6 no resp",   64'(seen),     64'd0);
    check("t6 resp_err",  64'(resp_err), 64'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
`endif
    hang = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
